pixel_histogram: RTL and testbench

Downstream consumer of the two-pixels-per-cycle RGB888 stream produced by the image reader stage. It converts each pixel to 8-bit luminance and accumulates a 256-bin intensity histogram over one full frame. It then streams the bins out over a valid/ready port for contrast analysis and threshold selection in the medical-image pipeline. Bins are cleared as they are read, so the block re-arms for the next frame without an idle clear pass.

---
 rtl/pixel_histogram.sv | 164 ++++++++++++++++
 tb/tb_pixel_histogram.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_histogram.sv
// pixel_histogram: 256-bin luminance histogram over one frame of a two-pixel-per-beat RGB888
// stream, streamed out over valid/ready with clear-on-read.
//
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   HSYNC                        beat qualifier (one beat = even + odd pixel)
//   DATA_{R,G,B}0 / DATA_{R,G,B}1  even / odd pixel colour components
//   rd_valid, rd_ready           readout handshake
//   rd_bin, rd_count             bin index and its pixel count
//   frame_done                   one-cycle pulse on entry to readout
//   overrun                      sticky flag: beat arrived while not accumulating
module pixel_histogram #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned BIN_W  = 19
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSYNC,
  input  logic [7:0]       DATA_R0,
  input  logic [7:0]       DATA_G0,
  input  logic [7:0]       DATA_B0,
  input  logic [7:0]       DATA_R1,
  input  logic [7:0]       DATA_G1,
  input  logic [7:0]       DATA_B1,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_bin,
  output logic [BIN_W-1:0] rd_count,
  output logic             frame_done,
  output logic             overrun
);

  localparam int unsigned FrameBeats = WIDTH * HEIGHT / 2;
  localparam int unsigned CntW       = (FrameBeats > 1) ? $clog2(FrameBeats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(FrameBeats - 1);

  typedef enum logic [1:0] {StAccum, StDrain, StRead} state_e;

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    return 8'(sum / 10'd3);
  endfunction

  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] a,
                                               input logic [1:0] inc);
    logic [BIN_W:0] s;
    s = {1'b0, a} + (BIN_W + 1)'(inc);
    return s[BIN_W] ? '1 : s[BIN_W-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic            frame_done_d;
  logic            overrun_d;
  logic            accept;
  logic            rd_fire;

  // Stage 1 registers
  logic       v1_q;
  logic [7:0] lum0_q, lum1_q;

  logic [BIN_W-1:0] bins_q [256];
  logic [BIN_W-1:0] bins_d [256];

  assign accept  = HSYNC && (state_q == StAccum);
  assign rd_fire = rd_valid && rd_ready;

  // Outputs
  assign rd_valid = (state_q == StRead);
  assign rd_bin   = idx_q;
  assign rd_count = rd_valid ? bins_q[idx_q] : '0;

  // FSM next state
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun | (HSYNC && (state_q != StAccum));
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            state_d    = StDrain;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        // Stage 2 lands the final beat this cycle.
        state_d      = StRead;
        frame_done_d = 1'b1;
      end
      StRead: begin
        if (rd_fire) begin
          idx_d = idx_q + 8'd1;  // wraps to 0 after bin 255
          if (idx_q == 8'd255) state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= StAccum;
      beat_cnt_q <= '0;
      idx_q      <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      idx_q      <= idx_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  // Stage 1: luminance capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      v1_q   <= 1'b0;
      lum0_q <= '0;
      lum1_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        lum0_q <= luma(DATA_R0, DATA_G0, DATA_B0);
        lum1_q <= luma(DATA_R1, DATA_G1, DATA_B1);
      end
    end
  end

  // Stage 2: bin update. Accumulation and readout are never active together (v1 is only
  // high in StAccum/StDrain), so clear-on-read simply follows the increments.
  always_comb begin
    bins_d = bins_q;
    if (v1_q) begin
      if (lum0_q == lum1_q) begin
        bins_d[lum0_q] = sat_add(bins_q[lum0_q], 2'd2);
      end else begin
        bins_d[lum0_q] = sat_add(bins_q[lum0_q], 2'd1);
        bins_d[lum1_q] = sat_add(bins_q[lum1_q], 2'd1);
      end
    end
    if (rd_fire) bins_d[idx_q] = '0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < 256; i++) bins_q[i] <= '0;
    end else begin
      bins_q <= bins_d;
    end
  end

endmodule

// File: tb/tb_pixel_histogram.sv
// Directed bench for pixel_histogram with a 4x2 frame (4 beats per frame).
module tb_pixel_histogram;

  localparam int unsigned BinW = 4;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic            HSYNC;
  logic [7:0]      DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic            rd_valid;
  logic            rd_ready;
  logic [7:0]      rd_bin;
  logic [BinW-1:0] rd_count;
  logic            frame_done;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  int exp_bins [256];

  pixel_histogram #(
    .WIDTH (4),
    .HEIGHT(2),
    .BIN_W (BinW)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSYNC     (HSYNC),
    .DATA_R0   (DATA_R0),
    .DATA_G0   (DATA_G0),
    .DATA_B0   (DATA_B0),
    .DATA_R1   (DATA_R1),
    .DATA_G1   (DATA_G1),
    .DATA_B1   (DATA_B1),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_bin    (rd_bin),
    .rd_count  (rd_count),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;
  endtask

  task automatic set_pix(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                         input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1);
    DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
    DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
  endtask

  // Four identical back-to-back beats, then the drain cycle and readout entry.
  task automatic send_frame(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                            input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1);
    set_pix(r0, g0, b0, r1, g1, b1);
    HSYNC = 1'b1;
    repeat (4) step();
    HSYNC = 1'b0;
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_done", 32'(frame_done), 32'd0);
    step();
    chk("read_valid", 32'(rd_valid), 32'd1);
    chk("frame_done", 32'(frame_done), 32'd1);
  endtask

  // Drain all 256 bins, checking index/count every cycle (stalled cycles included).
  task automatic read_frame(input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < 256 && cyc < 1000) begin
      rd_ready = toggle ? cyc[0] : 1'b1;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_bin", 32'(rd_bin), 32'(idx));
      chk("rd_count", 32'(rd_count), 32'(exp_bins[idx]));
      if (cyc == 1) chk("done_pulse", 32'(frame_done), 32'd0);
      if (rd_ready) idx++;
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("read_cycles", 32'(cyc), toggle ? 32'd512 : 32'd256);
    chk("post_valid", 32'(rd_valid), 32'd0);
    chk("post_bin", 32'(rd_bin), 32'd0);
  endtask

  initial begin
    HRESET   = 1'b1;
    HSYNC    = 1'b0;
    rd_ready = 1'b0;
    set_pix(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_bin", 32'(rd_bin), 32'd0);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    HRESET = 1'b0;
    repeat (5) begin
      step();
      chk("idle_valid", 32'(rd_valid), 32'd0);
    end

    // Uniform frame: (10+20+30)/3 = 20, 8 pixels
    clear_exp();
    exp_bins[20] = 8;
    send_frame(8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30);
    read_frame(1'b0);

    // Mixed beat: 765/3 = 255, 1/3 = 0
    clear_exp();
    exp_bins[255] = 4;
    exp_bins[0]   = 4;
    send_frame(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd1);
    read_frame(1'b0);

    // Sum rule (1,1,0) -> 0, plus (2,2,2) -> 2; read with backpressure
    clear_exp();
    exp_bins[0] = 4;
    exp_bins[2] = 4;
    send_frame(8'd1, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2);
    read_frame(1'b1);
    chk("no_overrun", 32'(overrun), 32'd0);

    // Overrun: beats during readout are dropped
    clear_exp();
    exp_bins[20] = 8;
    send_frame(8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30);
    set_pix(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    HSYNC = 1'b1;
    repeat (2) step();
    HSYNC = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    read_frame(1'b0);

    // Next frame of lum 5 sees only its own pixels
    clear_exp();
    exp_bins[5] = 8;
    send_frame(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    read_frame(1'b0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset after two beats discards the partial frame
    set_pix(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
    HSYNC = 1'b1;
    repeat (2) step();
    HSYNC  = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    step();
    HRESET = 1'b0;
    step();
    clear_exp();
    exp_bins[0] = 4;
    exp_bins[3] = 4;
    send_frame(8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3);
    read_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
